painterengine_gpu_dma_writer: RTL and testbench

AXI4 full write master for the GPU DMA path. It is the write-side counterpart of the GPU DMA read engine. It takes one of four stream sources selected by a one-hot router, then writes that source's 32-bit data words to memory as word-aligned INCR bursts. Each job runs once per reset: the block ends sticky in done or error, and the GPU control logic re-arms it by pulsing reset.

---
 rtl/painterengine_gpu_dma_writer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_painterengine_gpu_dma_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write master: drains one of four 32-bit word streams to memory as INCR bursts that never cross 1 KiB.
// Build option GPU_DMA_WRITER_BID_CHECK_EN: a write response carrying a nonzero BID ends the job with a PROTOCOL error.
module painterengine_gpu_dma_writer #(
   parameter int TIMEOUT_BIT = 18
) (
   input  logic         i_wire_clock,
   input  logic         i_wire_resetn,
   output logic         o_wire_done,
   input  logic [127:0] i_wire_address,
   input  logic [127:0] i_wire_length,
   input  logic [3:0]   i_wire_router,
   input  logic [127:0] i_wire_data,
   input  logic [3:0]   i_wire_data_valid,
   output logic [3:0]   o_wire_data_next,
   output logic         o_wire_error,
   output logic [2:0]   o_wire_error_type,
   output logic         o_wire_M_AXI_AWID,
   output logic [31:0]  o_wire_M_AXI_AWADDR,
   output logic [7:0]   o_wire_M_AXI_AWLEN,
   output logic [2:0]   o_wire_M_AXI_AWSIZE,
   output logic [1:0]   o_wire_M_AXI_AWBURST,
   output logic         o_wire_M_AXI_AWLOCK,
   output logic [3:0]   o_wire_M_AXI_AWCACHE,
   output logic [2:0]   o_wire_M_AXI_AWPROT,
   output logic [3:0]   o_wire_M_AXI_AWQOS,
   output logic         o_wire_M_AXI_AWVALID,
   input  logic         i_wire_M_AXI_AWREADY,
   output logic [31:0]  o_wire_M_AXI_WDATA,
   output logic [3:0]   o_wire_M_AXI_WSTRB,
   output logic         o_wire_M_AXI_WLAST,
   output logic         o_wire_M_AXI_WVALID,
   input  logic         i_wire_M_AXI_WREADY,
   input  logic         i_wire_M_AXI_BID,
   input  logic [1:0]   i_wire_M_AXI_BRESP,
   input  logic         i_wire_M_AXI_BVALID,
   output logic         o_wire_M_AXI_BREADY
);

   localparam int DATA_W = 32;

   localparam logic [2:0] ERR_OK         = 3'd0;
   localparam logic [2:0] ERR_ROUTER     = 3'd1;
   localparam logic [2:0] ERR_ADDRESS    = 3'd2;
   localparam logic [2:0] ERR_AW_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_W_TIMEOUT  = 3'd4;
   localparam logic [2:0] ERR_B_TIMEOUT  = 3'd5;
   localparam logic [2:0] ERR_BRESP      = 3'd6;
   localparam logic [2:0] ERR_PROTOCOL   = 3'd7;

   localparam logic [TIMEOUT_BIT:0] STALL_ONE = 1;

   typedef enum logic [3:0] {
      S_ROUTING,
      S_PARAM_CHECK,
      S_CALC_P0,
      S_CALC_P1,
      S_AW,
      S_WDATA,
      S_BRESP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   logic [DATA_W-1:0]     addr_r;
   logic [31:0]           len_r;
   logic [1:0]            idx_r;
   logic [31:0]           offset_r;
   logic [8:0]            beat_r;
   logic [TIMEOUT_BIT:0]  stall_r;
   logic [7:0]            unalign_p0;
   logic [8:0]            burstlen_r;
   logic [31:0]           awaddr_r;
   logic [7:0]            awlen_r;
   logic                  awvalid_r;
   logic [2:0]            error_type_r;

   logic                  route_ok;
   logic [1:0]            route_idx;
   logic [31:0]           remaining_w;
   logic [8:0]            aligned_w;
   logic [8:0]            blen_w;
   logic [31:0]           offset_next;
   logic [DATA_W-1:0]     lane_data;
   logic                  lane_valid;
   logic                  w_active;
   logic                  aw_fire;
   logic                  w_fire;
   logic                  w_last;
   logic                  bid_bad;

   // Burst length is the smaller of what is left of the job and what fits before the next 1 KiB line.
   function automatic logic [8:0] burst_len(input logic [31:0] remaining, input logic [8:0] aligned);
      if (remaining < {23'd0, aligned})
         burst_len = remaining[8:0];
      else
         burst_len = aligned;
   endfunction

   always_comb begin
      route_ok  = 1'b1;
      route_idx = 2'd0;
      case (i_wire_router)
         4'b0001: route_idx = 2'd0;
         4'b0010: route_idx = 2'd1;
         4'b0100: route_idx = 2'd2;
         4'b1000: route_idx = 2'd3;
         default: route_ok  = 1'b0;
      endcase
   end

`ifdef GPU_DMA_WRITER_BID_CHECK_EN
   assign bid_bad = i_wire_M_AXI_BID;
`else
   logic unused_bid;
   assign unused_bid = i_wire_M_AXI_BID;
   assign bid_bad    = 1'b0;
`endif

   assign remaining_w = len_r - offset_r;
   assign aligned_w   = 9'd256 - {1'b0, unalign_p0};
   assign blen_w      = burst_len(remaining_w, aligned_w);
   assign offset_next = offset_r + {23'd0, burstlen_r};

   assign lane_data  = i_wire_data[{idx_r, 5'd0} +: DATA_W];
   assign lane_valid = i_wire_data_valid[idx_r];
   assign w_active   = (state == S_WDATA);
   assign w_last     = w_active && (beat_r == burstlen_r - 9'd1);
   assign aw_fire    = awvalid_r && i_wire_M_AXI_AWREADY;
   assign w_fire     = w_active && lane_valid && i_wire_M_AXI_WREADY;

   assign o_wire_M_AXI_AWID    = 1'b0;
   assign o_wire_M_AXI_AWSIZE  = 3'b010;
   assign o_wire_M_AXI_AWBURST = 2'b01;
   assign o_wire_M_AXI_AWLOCK  = 1'b0;
   assign o_wire_M_AXI_AWCACHE = 4'b0010;
   assign o_wire_M_AXI_AWPROT  = 3'b000;
   assign o_wire_M_AXI_AWQOS   = 4'b0000;
   assign o_wire_M_AXI_AWADDR  = awaddr_r;
   assign o_wire_M_AXI_AWLEN   = awlen_r;
   assign o_wire_M_AXI_AWVALID = awvalid_r;

   // The W channel follows the selected source combinationally so a word is consumed in its handshake cycle.
   assign o_wire_M_AXI_WDATA  = lane_data;
   assign o_wire_M_AXI_WSTRB  = 4'hF;
   assign o_wire_M_AXI_WLAST  = w_last;
   assign o_wire_M_AXI_WVALID = w_active && lane_valid;
   assign o_wire_data_next    = w_fire ? (4'b0001 << idx_r) : 4'b0000;

   assign o_wire_M_AXI_BREADY = (state == S_BRESP);
   assign o_wire_done         = (state == S_DONE);
   assign o_wire_error        = (state == S_ERROR);
   assign o_wire_error_type   = error_type_r;

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state        <= S_ROUTING;
         addr_r       <= '0;
         len_r        <= '0;
         idx_r        <= '0;
         offset_r     <= '0;
         beat_r       <= '0;
         stall_r      <= '0;
         unalign_p0   <= '0;
         burstlen_r   <= '0;
         awaddr_r     <= '0;
         awlen_r      <= '0;
         awvalid_r    <= 1'b0;
         error_type_r <= ERR_OK;
      end else begin
         case (state)
            S_ROUTING: begin
               if (route_ok) begin
                  addr_r <= i_wire_address[{route_idx, 5'd0} +: 32];
                  len_r  <= i_wire_length[{route_idx, 5'd0} +: 32];
                  idx_r  <= route_idx;
                  state  <= S_PARAM_CHECK;
               end else begin
                  error_type_r <= ERR_ROUTER;
                  state        <= S_ERROR;
               end
            end
            S_PARAM_CHECK: begin
               if (addr_r[1:0] != 2'b00 || len_r == 32'd0) begin
                  error_type_r <= ERR_ADDRESS;
                  state        <= S_ERROR;
               end else begin
                  offset_r <= '0;
                  beat_r   <= '0;
                  stall_r  <= '0;
                  state    <= S_CALC_P0;
               end
            end
            // ---- burst planning stage 0: word position inside the current 1 KiB line
            S_CALC_P0: begin
               unalign_p0 <= addr_r[9:2] + offset_r[7:0];
               state      <= S_CALC_P1;
            end
            // ---- burst planning stage 1: clamp to the line end and to the words left
            S_CALC_P1: begin
               burstlen_r <= blen_w;
               awaddr_r   <= addr_r + (offset_r << 2);
               awlen_r    <= 8'(blen_w - 9'd1);
               awvalid_r  <= 1'b1;
               state      <= S_AW;
            end
            S_AW: begin
               if (stall_r[TIMEOUT_BIT]) begin
                  awvalid_r    <= 1'b0;
                  error_type_r <= ERR_AW_TIMEOUT;
                  state        <= S_ERROR;
               end else if (aw_fire) begin
                  awvalid_r <= 1'b0;
                  beat_r    <= '0;
                  stall_r   <= '0;
                  state     <= S_WDATA;
               end else begin
                  stall_r <= stall_r + STALL_ONE;
               end
            end
            S_WDATA: begin
               if (stall_r[TIMEOUT_BIT]) begin
                  error_type_r <= ERR_W_TIMEOUT;
                  state        <= S_ERROR;
               end else if (w_fire) begin
                  stall_r <= '0;
                  if (w_last) begin
                     beat_r <= '0;
                     state  <= S_BRESP;
                  end else begin
                     beat_r <= beat_r + 9'd1;
                  end
               end else begin
                  stall_r <= stall_r + STALL_ONE;
               end
            end
            S_BRESP: begin
               if (stall_r[TIMEOUT_BIT]) begin
                  error_type_r <= ERR_B_TIMEOUT;
                  state        <= S_ERROR;
               end else if (i_wire_M_AXI_BVALID) begin
                  stall_r <= '0;
                  if (bid_bad) begin
                     error_type_r <= ERR_PROTOCOL;
                     state        <= S_ERROR;
                  end else if (i_wire_M_AXI_BRESP != 2'b00) begin
                     error_type_r <= ERR_BRESP;
                     state        <= S_ERROR;
                  end else begin
                     offset_r <= offset_next;
                     state    <= (offset_next >= len_r) ? S_DONE : S_CALC_P0;
                  end
               end else begin
                  stall_r <= stall_r + STALL_ONE;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Randomized bench for painterengine_gpu_dma_writer: jobs are checked against a burst list cut at 1 KiB lines and a word list.
module tb_painterengine_gpu_dma_writer;
   localparam int TB_TIMEOUT_BIT = 7;
   localparam int TOUT = 1 << TB_TIMEOUT_BIT;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [127:0] address = '0;
   logic [127:0] length = '0;
   logic [127:0] data = '0;
   logic [3:0]   router = '0;
   logic [3:0]   data_valid = '0;
   logic [3:0]   data_next;
   logic         done, error;
   logic [2:0]   error_type;
   logic         awid, awlock, awvalid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize, awprot;
   logic [1:0]   awburst;
   logic [3:0]   awcache, awqos;
   logic         awready = 1'b0;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast, wvalid;
   logic         wready = 1'b0;
   logic         bid = 1'b0;
   logic [1:0]   bresp = 2'b00;
   logic         bvalid = 1'b0;
   logic         bready;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   painterengine_gpu_dma_writer #(.TIMEOUT_BIT(TB_TIMEOUT_BIT)) dut (
      .i_wire_clock(clk), .i_wire_resetn(resetn), .o_wire_done(done),
      .i_wire_address(address), .i_wire_length(length), .i_wire_router(router),
      .i_wire_data(data), .i_wire_data_valid(data_valid), .o_wire_data_next(data_next),
      .o_wire_error(error), .o_wire_error_type(error_type),
      .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
      .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
      .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
      .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
      .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
      .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
      .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
      .o_wire_M_AXI_BREADY(bready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      awready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      bresp      = 2'b00;
      bid        = 1'b0;
      data_valid = 4'b0000;
      data       = '0;
   endtask

   task automatic start_job(input logic [3:0] rt, input int lane, input logic [31:0] a, input logic [31:0] l);
      @(negedge clk);
      resetn = 1'b0;
      drive_idle();
      router = rt;
      for (int i = 0; i < 4; i++) begin
         address[i*32 +: 32] = $urandom & 32'hFFFF_FFFC;
         length[i*32 +: 32]  = $urandom_range(1, 50);
      end
      address[lane*32 +: 32] = a;
      length[lane*32 +: 32]  = l;
      #1;
      check("rst_awvalid", {31'd0, awvalid}, 0);
      check("rst_wvalid", {31'd0, wvalid}, 0);
      check("rst_bready", {31'd0, bready}, 0);
      check("rst_data_next", {28'd0, data_next}, 0);
      check("rst_flags", {29'd0, done, error, 1'b0} | {29'd0, error_type}, 0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // fault: 0 none, 1 bad BRESP, 2 nonzero BID, 3 AWREADY stuck low, 4 WREADY stuck low, 5 BVALID never
   // mode: 0 all ready, 1 random handshakes, 2 WREADY toggling with gapped source data
   task automatic run_job(input string name, input int lane, input logic [31:0] a, input int len,
                          input int mode, input int fault, input logic [2:0] exp_err);
      logic [31:0]     words[$];
      logic [31:0]     bur_a[$];
      int              bur_n[$];
      longint unsigned cur;
      int              rem, room, n, ph, ph0, bi, beat, ptr, aw_cnt, last_prog, budget, cyc, nb;
      logic            prev_aw, fin;
      logic [3:0]      rt;

      words.delete();
      bur_a.delete();
      bur_n.delete();
      for (int k = 0; k < len; k++) words.push_back($urandom);
      cur = a;
      rem = len;
      while (rem > 0) begin
         room = int'((64'd1024 - (cur % 64'd1024)) / 64'd4);
         n    = (room < rem) ? room : rem;
         bur_a.push_back(32'(cur));
         bur_n.push_back(n);
         cur += 64'(4 * n);
         rem -= n;
      end
      nb = bur_n.size();
      rt = 4'b0001 << lane;
      start_job(rt, lane, a, 32'(len));

      ph = 0; bi = 0; beat = 0; ptr = 0; aw_cnt = 0; last_prog = 0; cyc = 0;
      prev_aw = 1'b0; fin = 1'b0; wready = 1'b0;
      budget = 16 * len + 4 * TOUT + 200;
      while (!fin && cyc < budget) begin
         @(negedge clk);
         cyc++;
         ph0 = ph;
         awready = (fault == 3) ? 1'b0 : (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (fault == 4)      wready = 1'b0;
         else if (mode == 0)  wready = 1'b1;
         else if (mode == 2)  wready = ~wready;
         else                 wready = 1'($urandom_range(0, 1));
         data       = {$urandom, $urandom, $urandom, $urandom};
         data_valid = 4'($urandom);
         if (ptr < len) data[lane*32 +: 32] = words[ptr];
         data_valid[lane] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
         if (ph0 == 2 && fault != 5) begin
            bvalid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            bresp  = (fault == 1) ? 2'b10 : 2'b00;
            bid    = (fault == 2);
         end else if (ph0 == 1 && mode != 0) begin
            bvalid = ($urandom_range(0, 3) == 0);
            bresp  = 2'b11;
            bid    = 1'b1;
         end
         #1;
         if (awvalid && !prev_aw) last_prog = cyc;
         prev_aw = awvalid;
         if (ph0 == 1 && bvalid) check({name, "_bready_during_w"}, {31'd0, bready}, 0);
         if (awvalid && awready) begin
            last_prog = cyc;
            aw_cnt++;
            check({name, "_aw_phase"}, ph0, 0);
            check({name, "_aw_in_range"}, {31'd0, bi < nb}, 1);
            if (bi < nb) begin
               check({name, "_awaddr"}, awaddr, bur_a[bi]);
               check({name, "_awlen"}, {24'd0, awlen}, bur_n[bi] - 1);
            end
            check({name, "_aw_const"}, {awid, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
                  {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000, 4'hF});
            ph = 1;
            beat = 0;
         end
         if (wvalid && wready) begin
            last_prog = cyc;
            check({name, "_w_phase"}, ph0, 1);
            check({name, "_data_next_hs"}, {28'd0, data_next}, {28'd0, rt});
            if (ptr < len) check({name, "_wdata"}, wdata, words[ptr]);
            if (bi < nb) check({name, "_wlast"}, {31'd0, wlast}, {31'd0, beat == bur_n[bi] - 1});
            ptr++;
            beat++;
            if (bi < nb && beat == bur_n[bi]) ph = 2;
         end else begin
            check({name, "_data_next_idle"}, {28'd0, data_next}, 0);
         end
         if (bvalid && bready) begin
            last_prog = cyc;
            check({name, "_b_phase"}, ph0, 2);
            if (fault == 1 || fault == 2) ph = 3;
            else begin
               bi++;
               ph = (bi >= nb) ? 3 : 0;
            end
         end
         fin = done || error;
      end

      check({name, "_done"}, {31'd0, done}, {31'd0, exp_err == 3'd0});
      check({name, "_error"}, {31'd0, error}, {31'd0, exp_err != 3'd0});
      check({name, "_error_type"}, {29'd0, error_type}, {29'd0, exp_err});
      if (exp_err == 3'd0) begin
         check({name, "_words"}, ptr, len);
         check({name, "_bursts"}, bi, nb);
      end
      if (exp_err >= 3'd3 && exp_err <= 3'd5) begin
         check({name, "_timeout_not_early"}, {31'd0, (cyc - last_prog) >= TOUT}, 1);
         check({name, "_timeout_not_late"}, {31'd0, (cyc - last_prog) <= TOUT + 2}, 1);
      end
      if (fault == 1 || fault == 2) check({name, "_single_aw"}, aw_cnt, 1);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         awready = 1'b1; wready = 1'($urandom_range(0, 1));
         bvalid = 1'($urandom_range(0, 1)); bresp = 2'($urandom); bid = 1'($urandom);
         data_valid = 4'($urandom);
         #1;
         if (awvalid) prev_aw = 1'b1;
      end
      check({name, "_sticky_no_aw"}, {31'd0, prev_aw && fin}, 0);
      check({name, "_sticky_state"}, {29'd0, done, error, 1'b0} | {29'd0, error_type},
            {29'd0, exp_err == 3'd0, exp_err != 3'd0, 1'b0} | {29'd0, exp_err});
   endtask

   initial begin
      logic        got;
      logic        aw_seen;
      int          lane;
      logic [31:0] a;

      drive_idle();

      run_job("single16", 1, 32'h0000_1000, 16, 0, 0, 3'd0);
      run_job("cross1k", 0, 32'h0000_03F8, 10, 0, 0, 3'd0);
      run_job("gapped4", 2, 32'h0000_2040, 4, 2, 0, 3'd0);
      run_job("long600", 3, 32'h0000_2000, 600, 1, 0, 3'd0);
      for (int j = 0; j < 6; j++) begin
         lane = $urandom_range(0, 3);
         a    = (32'($urandom_range(0, 255)) << 10) | (32'($urandom_range(0, 255)) << 2);
         run_job("rand", lane, a, $urandom_range(1, 320), 1, 0, 3'd0);
      end

      start_job(4'b0011, 0, 32'h0000_1000, 16);
      aw_seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         if (awvalid) aw_seen = 1'b1;
      end
      check("router_multi_error", {29'd0, error, error_type[1:0]}, {29'd0, 1'b1, 2'd1});
      check("router_multi_type", {29'd0, error_type}, 1);
      check("router_multi_no_aw", {31'd0, aw_seen}, 0);

      start_job(4'b0000, 2, 32'h0000_1000, 16);
      repeat (2) @(negedge clk);
      #1;
      check("router_zero_type", {28'd0, error, error_type}, {28'd0, 1'b1, 3'd1});

      start_job(4'b0100, 2, 32'h0000_1002, 8);
      repeat (3) @(negedge clk);
      #1;
      check("addr_unaligned_type", {28'd0, error, error_type}, {28'd0, 1'b1, 3'd2});

      start_job(4'b1000, 3, 32'h0000_2000, 0);
      repeat (3) @(negedge clk);
      #1;
      check("len_zero_type", {28'd0, error, error_type}, {28'd0, 1'b1, 3'd2});

      run_job("bresp_err", 0, 32'h0000_0400, 8, 0, 1, 3'd6);
      run_job("aw_timeout", 1, 32'h0000_0800, 8, 0, 3, 3'd3);
      run_job("w_timeout", 2, 32'h0000_0C00, 8, 0, 4, 3'd4);
      run_job("b_timeout", 3, 32'h0000_1400, 8, 0, 5, 3'd5);
`ifdef GPU_DMA_WRITER_BID_CHECK_EN
      run_job("bid_err", 0, 32'h0000_1800, 8, 0, 2, 3'd7);
`endif

      start_job(4'b0001, 0, 32'h0000_0100, 64);
      awready = 1'b1; wready = 1'b1; data_valid = 4'b0001;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         got = wvalid;
      end
      check("midburst_w_started", {31'd0, got}, 1);
      #1 resetn = 1'b0;
      #1;
      check("midburst_rst_outputs", {28'd0, awvalid, wvalid, bready, |data_next}, 0);
      drive_idle();
      @(negedge clk);
      resetn = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
